// File: rtl/inst_sched_pkg.sv
// Shared types and sizing helpers for the round-robin instance scheduler.
package inst_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int DEF_NUM_REQ = 5;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  // Index width that never collapses to zero bits for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inst_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr+1, wrapping.
module inst_rr_pick
  import inst_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [ID_W-1:0]    win_id,
  output logic               win_valid
);

  always_comb begin
    int idx;
    idx        = 0;
    win_onehot = '0;
    win_id     = '0;
    win_valid  = 1'b0;
    // Offset NUM_REQ lands back on ptr itself, so the last holder has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!win_valid && req[idx]) begin
        win_valid       = 1'b1;
        win_id          = ID_W'(idx);
        win_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_rr_sched.sv
// Round-robin scheduler granting one leaf instance at a time until it signals done.
// Optional grant timeout enabled by defining INST_SCHED_TIMEOUT_EN.
module inst_rr_sched
  import inst_sched_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [id_width(NUM_REQ)-1:0]  gnt_id,
  output logic                          busy
`ifdef INST_SCHED_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int ID_W = id_width(NUM_REQ);

  sched_state_t       state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [ID_W-1:0]    gnt_id_reg;
  logic [ID_W-1:0]    ptr_reg;
  logic               busy_reg;

  logic [NUM_REQ-1:0] win_onehot;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic [NUM_REQ-1:0] done_mask;
  logic               done_hit;

`ifdef INST_SCHED_TIMEOUT_EN
  localparam int CNT_W = id_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_err_reg;
`endif

  inst_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_reg),
    .win_onehot (win_onehot),
    .win_id     (win_id),
    .win_valid  (win_valid)
  );

  // Only the current holder's done bit can end a grant; gnt is zero in IDLE.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done_mask
    assign done_mask[gi] = done[gi] & gnt_reg[gi];
  end
  assign done_hit = |done_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      gnt_id_reg <= '0;
      busy_reg   <= 1'b0;
      ptr_reg    <= ID_W'(NUM_REQ - 1);
`ifdef INST_SCHED_TIMEOUT_EN
      cnt_reg         <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
`ifdef INST_SCHED_TIMEOUT_EN
      timeout_err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg  <= BUSY;
            gnt_reg    <= win_onehot;
            gnt_id_reg <= win_id;
            ptr_reg    <= win_id;
            busy_reg   <= 1'b1;
`ifdef INST_SCHED_TIMEOUT_EN
            cnt_reg    <= '0;
`endif
          end
        end
        BUSY: begin
          if (done_hit) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
          end
`ifdef INST_SCHED_TIMEOUT_EN
          // Forced release leaves ptr alone so the stalled holder keeps its slot in the rotation.
          else if (cnt_reg == CNT_LAST) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
`endif
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign busy   = busy_reg;
`ifdef INST_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_reg;
`endif

endmodule

// File: tb/tb_inst_rr_sched.sv
// Randomized plus directed bench for inst_rr_sched against a behavioural round-robin model.
module tb_inst_rr_sched;

  localparam int N  = 5;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_id;
  logic         busy;
`ifdef INST_SCHED_TIMEOUT_EN
  logic         timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  // Model: who holds the slot, who held it last, and how many BUSY cycles it has seen.
  bit m_busy;
  int m_id;
  int m_last;
  int m_age;
  bit m_to;

  inst_rr_sched #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy)
`ifdef INST_SCHED_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] v;
    v = '0;
    if (m_busy) v[m_id] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_last = N - 1;
    m_age  = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    m_to = 1'b0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (r[i]) begin
          m_busy = 1'b1;
          m_id   = i;
          m_last = i;
          m_age  = 1;
          $display("grant id=%0d req=%b t=%0t", i, r, $time);
          break;
        end
      end
    end else if (d[m_id]) begin
      m_busy = 1'b0;
    end
`ifdef INST_SCHED_TIMEOUT_EN
    else if (m_age == TO) begin
      m_busy = 1'b0;
      m_to   = 1'b1;
    end else begin
      m_age++;
    end
`endif
  endtask

  task automatic compare_all();
    chk("gnt", 32'(gnt), 32'(m_gnt()));
    chk("gnt_id", 32'(gnt_id), 32'(m_id));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("onehot", 32'($onehot0(gnt)), 32'd1);
`ifdef INST_SCHED_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'(m_to));
`endif
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    compare_all();
  endtask

  // Asserts reset away from any clock edge and checks it takes effect before the next edge.
  task automatic apply_reset();
    #2;
    rst  = 1'b1;
    req  = '0;
    done = '0;
    #1;
    model_reset();
    compare_all();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int exp_order[6];
    logic [N-1:0] r;
    logic [N-1:0] d;
    exp_order = '{0, 1, 2, 3, 4, 0};

    apply_reset();
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);

    // First grant one cycle after release.
    cycle(5'b00001, 5'b00000);
    chk("first_gnt", 32'(gnt), 32'b00001);
    chk("first_id", 32'(gnt_id), 32'd0);
    chk("first_busy", 32'(busy), 32'd1);
    cycle(5'b00001, 5'b00001);
    chk("first_release", 32'(busy), 32'd0);

    // Full rotation with one IDLE cycle between grants.
    apply_reset();
    for (int g = 0; g < 6; g++) begin
      logic [N-1:0] dh;
      dh = '0;
      dh[exp_order[g]] = 1'b1;
      cycle(5'b11111, 5'b00000);
      chk("rot_id", 32'(gnt_id), 32'(exp_order[g]));
      chk("rot_busy", 32'(busy), 32'd1);
      cycle(5'b11111, dh);
      chk("rot_idle", 32'(busy), 32'd0);
    end

    // Grant holds through dropped req and foreign done.
    apply_reset();
    cycle(5'b00100, 5'b00000);
    chk("hold_gnt0", 32'(gnt), 32'b00100);
    for (int c = 0; c < 4; c++) begin
      cycle(5'b00000, 5'b01000);
      chk("hold_gnt", 32'(gnt), 32'b00100);
    end
    cycle(5'b00000, 5'b00100);
    chk("hold_release", 32'(gnt), 32'd0);
    chk("idle_keeps_id", 32'(gnt_id), 32'd2);

    // Wrap from ptr=4 to id 0, then id 4.
    apply_reset();
    cycle(5'b10001, 5'b00000);
    chk("wrap_id0", 32'(gnt_id), 32'd0);
    cycle(5'b10001, 5'b00001);
    chk("wrap_idle", 32'(busy), 32'd0);
    cycle(5'b10001, 5'b00000);
    chk("wrap_id4", 32'(gnt_id), 32'd4);
    cycle(5'b00000, 5'b10000);

    // Reset during a grant on id 3.
    apply_reset();
    cycle(5'b01000, 5'b00000);
    chk("mid_id3", 32'(gnt_id), 32'd3);
    apply_reset();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    cycle(5'b01000, 5'b00000);
    chk("post_rst_gnt", 32'(gnt), 32'b01000);
    chk("post_rst_id", 32'(gnt_id), 32'd3);

`ifdef INST_SCHED_TIMEOUT_EN
    // Expiry without done, then done on the final BUSY cycle.
    apply_reset();
    cycle(5'b00010, 5'b00000);
    for (int c = 1; c < TO; c++) begin
      cycle(5'b00010, 5'b00000);
      chk("to_wait_busy", 32'(busy), 32'd1);
    end
    cycle(5'b00000, 5'b00000);
    chk("to_pulse", 32'(timeout_err), 32'd1);
    chk("to_release", 32'(busy), 32'd0);
    cycle(5'b00000, 5'b00000);
    chk("to_pulse_end", 32'(timeout_err), 32'd0);
    cycle(5'b00010, 5'b00000);
    for (int c = 1; c < TO; c++) cycle(5'b00010, 5'b00000);
    cycle(5'b00000, 5'b00010);
    chk("to_done_last", 32'(timeout_err), 32'd0);
    chk("to_done_rel", 32'(busy), 32'd0);
`endif

    // Random traffic with occasional reset.
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      d = N'($urandom) & N'($urandom);
      if (m_busy && $urandom_range(0, 3) == 0) d[m_id] = 1'b1;
      if ($urandom_range(0, 199) == 0) apply_reset();
      else cycle(r, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rr_sched.md
INST_RR_SCHED -- requirements
Module: inst_rr_sched

Interface
REQ-001 Parameter NUM_REQ, default 5, number of leaf instances sharing the scheduled slot.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, maximum grant length in cycles; used only with the timeout feature.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  NUM_REQ  per-instance request level.
REQ-006 done  input  NUM_REQ  per-instance completion pulse.
REQ-007 gnt  output  NUM_REQ  one-hot grant, registered.
REQ-008 gnt_id  output  $clog2(NUM_REQ)  index of the granted instance; valid while busy=1.
REQ-009 busy  output  1  high while any grant is active.
REQ-010 timeout_err  output  1  one-cycle pulse on forced release; exists only with the timeout feature.

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt=0) and BUSY (exactly one gnt bit high).
REQ-012 IDLE with req!=0 sampled SHALL go to BUSY; gnt, gnt_id and busy SHALL assert on the next edge (1-cycle latency).
REQ-013 The winner SHALL be the first set req bit scanning upward from ptr+1 modulo NUM_REQ; index NUM_REQ-1 wraps to 0.
REQ-014 On each grant, ptr SHALL load the winner index.
REQ-015 In BUSY, gnt SHALL hold regardless of req changes until done[gnt_id]=1 is sampled.
REQ-016 done bits of non-granted instances SHALL be ignored in all states.
REQ-017 On sampled done[gnt_id], the next edge SHALL clear gnt and busy and return to IDLE; at least one IDLE cycle SHALL separate consecutive grants.
REQ-018 done[gnt_id] together with new req in the same cycle SHALL end the grant; the new req is arbitrated in the following IDLE cycle.
REQ-019 A single requester holding req high SHALL be regranted after each intervening IDLE cycle.
REQ-020 gnt_id SHALL retain its last value in IDLE; gnt SHALL never have more than one bit set.

Reset
REQ-021 Reset SHALL immediately force gnt=0, gnt_id=0, busy=0, timeout_err=0, state=IDLE, grant counter=0 and ptr=NUM_REQ-1, so index 0 has first priority.
REQ-022 Reset asserted mid-grant SHALL drop the grant without waiting for done.
REQ-023 After release, the first arbitration SHALL occur on the first edge at which req is sampled.

Configuration
REQ-024 Macro INST_SCHED_TIMEOUT_EN defined: a counter SHALL clear on grant and increment each BUSY cycle.
REQ-025 With INST_SCHED_TIMEOUT_EN, if the counter reaches TIMEOUT_CYCLES-1 without done, the next edge SHALL clear gnt, return to IDLE and pulse timeout_err for one cycle; ptr is unchanged.
REQ-026 With INST_SCHED_TIMEOUT_EN, done in the same cycle as expiry SHALL count as a normal completion with no timeout_err.
REQ-027 Macro INST_SCHED_TIMEOUT_EN undefined: no counter and no timeout_err port; grants SHALL be unbounded.

Structure
REQ-028 Package inst_sched_pkg SHALL hold the state enum (IDLE, BUSY), the default NUM_REQ and the ID-width localparam.
REQ-029 A combinational sub-module inst_rr_pick SHALL take req and ptr and return the winner one-hot and index; inst_rr_sched instantiates it once.

Verification
REQ-030 Reset release with req=5'b00001 SHALL give gnt=5'b00001, gnt_id=0 and busy=1 one cycle later.
REQ-031 req=5'b11111 with done pulsed on each grant SHALL give grant order 0,1,2,3,4,0, with one IDLE cycle between grants.
REQ-032 Grant on id 2 with req[2] dropped and done[3] pulsed SHALL hold gnt=5'b00100 until done[2].
REQ-033 ptr=4 and req=5'b10001 SHALL grant id 0 (wrap); the next grant after done SHALL be id 4.
REQ-034 Reset asserted during BUSY on id 3 SHALL clear gnt within the same cycle; with req=5'b01000 after release, id 0 has priority but id 3 SHALL be granted.
REQ-035 With INST_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, a grant with no done SHALL release after 16 BUSY cycles with a single timeout_err pulse; done on cycle 16 SHALL give no pulse.
